nn_layer_stream: RTL and testbench
==================================

// Module: nn_layer_stream
// PURPOSE
// - Parametrised fully-connected layer: NN MAC lanes share one serial input stream, each lane holding its own weight RAM and bias.
// - Adds what the fixed per-neuron layers lack: runtime weight/bias load filtered by layer/neuron ID, an FSM-sequenced frame, and an output serializer with ready/valid backpressure.
// - Sits between layers: the serial output feeds the next layer's x_in directly.
// PARAMETERS
// - NN 8 : neurons (lanes) in the layer, 1..64
// - NUM_WEIGHT 784 : inputs per frame = weights per lane
// - DATA_WIDTH 16 : signed width of x, w, bias and outputs
// - WEIGHT_INT_WIDTH 4 : integer bits (incl. sign); fraction = DATA_WIDTH-WEIGHT_INT_WIDTH
// - LAYER_NUM 1 : ID this layer answers to on config_layer_num
// - ACT_TYPE "relu" : "relu" or "none"
// PORTS
// - clk  in 1 : single clock
// - rst  in 1 : asynchronous, active-low reset
// - weightValid/biasValid  in 1 : config write strobes
// - weightValue/biasValue  in 32 : config data, low DATA_WIDTH bits used
// - config_layer_num/config_neuron_num  in 32 : config target
// - x_valid in 1, x_ready out 1, x_in in DATA_WIDTH : input stream
// - o_valid out NN, x_out out NN*DATA_WIDTH : parallel results, lane k at [k*DATA_WIDTH+:DATA_WIDTH]
// - y_valid out 1, y_ready in 1, y_data out DATA_WIDTH, y_last out 1 : serial result stream
// - cfg_err out 1 : one-cycle pulse on rejected config write
// BEHAVIOUR
// - Reset: all outputs 0, FSM=ACCUM, counters/accumulators/bias regs 0; weight RAMs not reset.
// - FSM: ACCUM -> DRAIN -> BIAS -> ACT -> SHIFT -> ACCUM.
// - ACCUM: x_ready=1; each x_valid&x_ready beat reads w[cnt] in all lanes, cnt++. At cnt=NUM_WEIGHT-1 accepted, go DRAIN.
// - Datapath: product registered (1 cycle), accumulated next cycle; DRAIN waits for last accumulate. ACC width 2*DATA_WIDTH+$clog2(NUM_WEIGHT)+1, no overflow possible.
// - BIAS: acc += bias << fraction bits. ACT: take acc >> fraction bits, saturate to [-2^(DW-1), 2^(DW-1)-1], relu zeroes negatives; register x_out, pulse o_valid (all lanes) for 1 cycle.
// - Latency: last input beat at cycle t -> o_valid at t+4, first y_valid at t+5.
// - SHIFT: emit lane 0..NN-1 one per accepted beat; y_data/y_valid held stable while y_ready=0; y_last with lane NN-1; after that beat go ACCUM.
// - x_ready=0 outside ACCUM; x_valid then is ignored, not buffered.
// - Config: accepted only when config_layer_num==LAYER_NUM and config_neuron_num<NN. weightValid writes w[wptr[n]], wptr[n] wraps NUM_WEIGHT-1 -> 0. biasValid overwrites bias[n].
// - Config write while cnt!=0 or FSM!=ACCUM: dropped, cfg_err=1 for 1 cycle. Mismatched layer ID: silently ignored (other layers' traffic). Matching layer, neuron>=NN: cfg_err.
// - weightValid and biasValid same cycle: both applied.
// - Reset mid-frame: partial accumulation discarded, no y_valid until a full new frame.
// STRUCTURE
// - Package nn_pkg: act_e (ACT_RELU, ACT_NONE), layer_state_e, function sat_dw(acc) and localparam helpers FRAC_W, ACC_W.
// - Sub-module nn_mac_lane: weight RAM, wptr, bias reg, multiply/accumulate/bias/activation pipeline; generate-instantiated NN times.
// - Top: FSM, input counter, config decode, serializer mux.
// TESTING (NN=4, NUM_WEIGHT=4, DW=16, WIW=4)
// - All w=0x1000 (1.0), bias 0, x=0x0800 x4 -> x_out lanes 0x2000, y 4 beats 0x2000, y_last on beat 4.
// - w=0xF000 (-1.0), x=0x1000 x4: relu -> 0x0000; ACT_TYPE "none" -> 0xC000.
// - w=x=0x7FFF x4 -> 0x7FFF; w=0x8000, x=0x7FFF, "none" -> 0x8000 (saturation both ways).
// - y_ready low 3 cycles at beat 2 -> y_data held, x_ready stays 0, all 4 values delivered in order.
// - Config layer 2 (LAYER_NUM=1) -> weights unchanged, no cfg_err; neuron 5 -> cfg_err pulse; write mid-frame -> cfg_err, result unaffected.
// - rst low after 2 inputs -> all outputs 0; next full frame gives 0x2000 per lane as in test 1.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and elaboration helpers for the streaming fully-connected layer.
//   act_e          : activation selected per layer instance
//   layer_state_e  : frame sequencer states
//   frac_w/acc_w   : fraction-bit count and lossless accumulator width
//   addr_w         : index width for a table of n entries (minimum 1 bit)
//   sat_dw         : clamp a wide signed value to a dw-bit signed range
package nn_pkg;

  typedef enum logic {
    ACT_RELU,
    ACT_NONE
  } act_e;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_BIAS,
    ST_ACT,
    ST_SHIFT
  } layer_state_e;

  // Width of the intermediate fed to sat_dw; wide enough for any accumulator
  // this layer can elaborate with.
  localparam int unsigned SAT_W = 128;

  function automatic int unsigned frac_w(input int unsigned dw, input int unsigned wiw);
    return dw - wiw;
  endfunction

  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned nw);
    return 2 * dw + $clog2(nw) + 1;
  endfunction

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] v,
                                                     input int unsigned             dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
    lo = -(SAT_W'(1) <<< (dw - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One neuron of the layer: weight RAM with auto-incrementing write pointer,
// bias register, registered multiply, accumulate, bias add and activation.
//   clk_i, rst_ni          : clock, async active-low reset
//   w_we_i / w_data_i      : append one weight at the lane's write pointer
//   b_we_i / b_data_i      : overwrite the bias
//   beat_i, rd_addr_i, x_i : accepted input sample and the weight index it uses
//   bias_i                 : add the bias (aligned to the product fraction)
//   act_i                  : register activated result, clear the accumulator
//   y_o                    : registered activated result
module nn_mac_lane
  import nn_pkg::*;
#(
  parameter int unsigned NUM_WEIGHT       = 784,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned WEIGHT_INT_WIDTH = 4,
  parameter act_e        ACT              = ACT_RELU
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              w_we_i,
  input  logic [DATA_WIDTH-1:0]             w_data_i,
  input  logic                              b_we_i,
  input  logic [DATA_WIDTH-1:0]             b_data_i,
  input  logic                              beat_i,
  input  logic [addr_w(NUM_WEIGHT)-1:0]     rd_addr_i,
  input  logic [DATA_WIDTH-1:0]             x_i,
  input  logic                              bias_i,
  input  logic                              act_i,
  output logic [DATA_WIDTH-1:0]             y_o
);

  localparam int unsigned FRAC = frac_w(DATA_WIDTH, WEIGHT_INT_WIDTH);
  localparam int unsigned ACCW = acc_w(DATA_WIDTH, NUM_WEIGHT);
  localparam int unsigned AW   = addr_w(NUM_WEIGHT);

  logic [DATA_WIDTH-1:0]          wram [NUM_WEIGHT];
  logic [AW-1:0]                  wptr_q, wptr_d;
  logic signed [DATA_WIDTH-1:0]   bias_q;
  logic signed [2*DATA_WIDTH-1:0] prod_q;
  logic                           pvalid_q;
  logic signed [ACCW-1:0]         acc_q, acc_d;
  logic [DATA_WIDTH-1:0]          y_q;

  logic signed [DATA_WIDTH-1:0]   x_s, w_s;
  logic signed [ACCW-1:0]         acc_sh;
  logic signed [SAT_W-1:0]        sat_v;
  logic [DATA_WIDTH-1:0]          act_val;

  assign x_s = x_i;
  assign w_s = wram[rd_addr_i];
  assign y_o = y_q;

  assign wptr_d = (wptr_q == AW'(NUM_WEIGHT - 1)) ? '0 : wptr_q + 1'b1;

  // Weight storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (w_we_i) wram[wptr_q] <= w_data_i;
  end

  // Only one of accumulate / bias / clear is ever requested in a cycle; the
  // product of the final beat lands during the sequencer's drain cycle.
  always_comb begin
    acc_d = acc_q;
    if (act_i)         acc_d = '0;
    else if (pvalid_q) acc_d = acc_q + ACCW'(prod_q);
    else if (bias_i)   acc_d = acc_q + (ACCW'(bias_q) <<< FRAC);
  end

  always_comb begin
    acc_sh  = acc_q >>> FRAC;
    sat_v   = sat_dw(SAT_W'(acc_sh), DATA_WIDTH);
    act_val = sat_v[DATA_WIDTH-1:0];
    if (ACT == ACT_RELU && sat_v[SAT_W-1]) act_val = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      bias_q   <= '0;
      prod_q   <= '0;
      pvalid_q <= 1'b0;
      acc_q    <= '0;
      y_q      <= '0;
    end else begin
      if (w_we_i) wptr_q <= wptr_d;
      if (b_we_i) bias_q <= b_data_i;
      pvalid_q <= beat_i;
      if (beat_i) prod_q <= x_s * w_s;
      acc_q <= acc_d;
      if (act_i) y_q <= act_val;
    end
  end

endmodule

// File: rtl/nn_layer_stream.sv
// Streaming fully-connected layer: NN MAC lanes share one serial input
// stream; results are presented in parallel and then serialized with
// ready/valid so the output can feed the next layer's input directly.
//   clk, rst (async, active-low)
//   weightValid/weightValue, biasValid/biasValue : config writes
//   config_layer_num/config_neuron_num           : config target
//   x_valid/x_ready/x_in                         : input stream
//   o_valid/x_out                                : parallel results (1-cycle pulse)
//   y_valid/y_ready/y_data/y_last                : serial results, lane 0 first
//   cfg_err                                      : rejected config write pulse
module nn_layer_stream
  import nn_pkg::*;
#(
  parameter int unsigned NN               = 8,
  parameter int unsigned NUM_WEIGHT       = 784,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned WEIGHT_INT_WIDTH = 4,
  parameter int unsigned LAYER_NUM        = 1,
  parameter              ACT_TYPE         = "relu"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       weightValid,
  input  logic                       biasValid,
  input  logic [31:0]                weightValue,
  input  logic [31:0]                biasValue,
  input  logic [31:0]                config_layer_num,
  input  logic [31:0]                config_neuron_num,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic [DATA_WIDTH-1:0]      x_in,
  output logic [NN-1:0]              o_valid,
  output logic [NN*DATA_WIDTH-1:0]   x_out,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [DATA_WIDTH-1:0]      y_data,
  output logic                       y_last,
  output logic                       cfg_err
);

  localparam act_e        ACT = (ACT_TYPE == "none") ? ACT_NONE : ACT_RELU;
  localparam int unsigned CW  = addr_w(NUM_WEIGHT);
  localparam int unsigned IW  = addr_w(NN);

  layer_state_e          state_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         idx_q;
  logic                  x_ready_q;
  logic                  o_valid_q;
  logic                  y_valid_q;
  logic [DATA_WIDTH-1:0] y_data_q;
  logic                  y_last_q;
  logic                  cfg_err_q;

  logic                  beat;
  logic                  cfg_any, layer_hit, neuron_ok, cfg_busy, cfg_accept, cfg_reject;
  logic [DATA_WIDTH-1:0] lane_y [NN];

  assign x_ready = x_ready_q;
  assign o_valid = {NN{o_valid_q}};
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_last  = y_last_q;
  assign cfg_err = cfg_err_q;

  // x_ready_q is only ever set while in ACCUM, so it alone qualifies a beat.
  assign beat = x_valid & x_ready_q;

  // Writes to other layers are not ours to flag; writes for this layer are
  // only safe between frames, before the first sample of the next frame.
  assign cfg_any    = weightValid | biasValid;
  assign layer_hit  = (config_layer_num == 32'(LAYER_NUM));
  assign neuron_ok  = (config_neuron_num < 32'(NN));
  assign cfg_busy   = (cnt_q != '0) || (state_q != ST_ACCUM);
  assign cfg_accept = cfg_any & layer_hit & neuron_ok & ~cfg_busy;
  assign cfg_reject = cfg_any & layer_hit & (~neuron_ok | cfg_busy);

  for (genvar k = 0; k < NN; k++) begin : g_lane
    logic sel;
    assign sel = cfg_accept & (config_neuron_num == 32'(k));

    nn_mac_lane #(
      .NUM_WEIGHT      (NUM_WEIGHT),
      .DATA_WIDTH      (DATA_WIDTH),
      .WEIGHT_INT_WIDTH(WEIGHT_INT_WIDTH),
      .ACT             (ACT)
    ) u_lane (
      .clk_i    (clk),
      .rst_ni   (rst),
      .w_we_i   (sel & weightValid),
      .w_data_i (weightValue[DATA_WIDTH-1:0]),
      .b_we_i   (sel & biasValid),
      .b_data_i (biasValue[DATA_WIDTH-1:0]),
      .beat_i   (beat),
      .rd_addr_i(cnt_q),
      .x_i      (x_in),
      .bias_i   (state_q == ST_BIAS),
      .act_i    (state_q == ST_ACT),
      .y_o      (lane_y[k])
    );

    assign x_out[k*DATA_WIDTH +: DATA_WIDTH] = lane_y[k];
  end

  if (DATA_WIDTH < 32) begin : g_cfg_unused
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{weightValue[31:DATA_WIDTH], biasValue[31:DATA_WIDTH]};
  end

  // Sequencer. x_ready_q comes up one cycle after reset release and tracks
  // ACCUM from then on. The serializer loads lane 0 on SHIFT entry, then
  // advances one lane per accepted beat and returns to ACCUM after y_last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_ACCUM;
      cnt_q     <= '0;
      idx_q     <= '0;
      x_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      cfg_err_q <= cfg_reject;
      unique case (state_q)
        ST_ACCUM: begin
          x_ready_q <= 1'b1;
          if (beat) begin
            if (cnt_q == CW'(NUM_WEIGHT - 1)) begin
              cnt_q     <= '0;
              x_ready_q <= 1'b0;
              state_q   <= ST_DRAIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: state_q <= ST_BIAS;
        ST_BIAS:  state_q <= ST_ACT;
        ST_ACT: begin
          o_valid_q <= 1'b1;
          idx_q     <= '0;
          state_q   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!y_valid_q) begin
            y_valid_q <= 1'b1;
            y_data_q  <= lane_y[idx_q];
            y_last_q  <= (idx_q == IW'(NN - 1));
            idx_q     <= idx_q + 1'b1;
          end else if (y_ready) begin
            if (y_last_q) begin
              y_valid_q <= 1'b0;
              y_last_q  <= 1'b0;
              x_ready_q <= 1'b1;
              state_q   <= ST_ACCUM;
            end else begin
              y_data_q <= lane_y[idx_q];
              y_last_q <= (idx_q == IW'(NN - 1));
              idx_q    <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_stream.sv
module tb_nn_layer_stream;

  localparam int NN = 4;
  localparam int NW = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          weightValid, biasValid, x_valid, y_ready;
  logic [31:0]   weightValue, biasValue, config_layer_num, config_neuron_num;
  logic [DW-1:0] x_in;

  logic             x_ready_r, y_valid_r, y_last_r, cfg_err_r;
  logic [NN-1:0]    o_valid_r;
  logic [NN*DW-1:0] x_out_r;
  logic [DW-1:0]    y_data_r;
  logic             x_ready_n, y_valid_n, y_last_n, cfg_err_n;
  logic [NN-1:0]    o_valid_n;
  logic [NN*DW-1:0] x_out_n;
  logic [DW-1:0]    y_data_n;

  nn_layer_stream #(
    .NN(NN), .NUM_WEIGHT(NW), .DATA_WIDTH(DW), .WEIGHT_INT_WIDTH(4),
    .LAYER_NUM(1), .ACT_TYPE("relu")
  ) u_relu (
    .clk(clk), .rst(rst),
    .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .x_valid(x_valid), .x_ready(x_ready_r), .x_in(x_in),
    .o_valid(o_valid_r), .x_out(x_out_r),
    .y_valid(y_valid_r), .y_ready(y_ready), .y_data(y_data_r), .y_last(y_last_r),
    .cfg_err(cfg_err_r)
  );

  nn_layer_stream #(
    .NN(NN), .NUM_WEIGHT(NW), .DATA_WIDTH(DW), .WEIGHT_INT_WIDTH(4),
    .LAYER_NUM(1), .ACT_TYPE("none")
  ) u_none (
    .clk(clk), .rst(rst),
    .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .x_valid(x_valid), .x_ready(x_ready_n), .x_in(x_in),
    .o_valid(o_valid_n), .x_out(x_out_n),
    .y_valid(y_valid_n), .y_ready(y_ready), .y_data(y_data_n), .y_last(y_last_n),
    .cfg_err(cfg_err_n)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int w_m [NN][NW];
  int b_m [NN];
  int wp_m[NN];
  int xs_cur[NW];

  int yq_r[$], yq_n[$];
  logic [NN*DW-1:0] oq_r[$], oq_n[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_edge = 0;
  bit lat_o_pending = 1'b0;
  bit lat_y_pending = 1'b0;
  int ybeat = 0;

  function automatic longint sx(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  function automatic int exp_val(input int lane, input bit relu);
    longint s;
    s = 0;
    for (int j = 0; j < NW; j++) s += sx(xs_cur[j]) * sx(w_m[lane][j]);
    s += sx(b_m[lane]) <<< 12;
    s = s >>> 12;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return int'(s) & 32'hFFFF;
  endfunction

  task automatic push_expect();
    logic [NN*DW-1:0] fr, fn;
    int er, en;
    for (int k = 0; k < NN; k++) begin
      er = exp_val(k, 1'b1);
      en = exp_val(k, 1'b0);
      yq_r.push_back(er);
      yq_n.push_back(en);
      fr[k*DW +: DW] = 16'(er);
      fn[k*DW +: DW] = 16'(en);
    end
    oq_r.push_back(fr);
    oq_n.push_back(fn);
  endtask

  // Output monitor / scoreboard; samples on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (|o_valid_r) begin
        chk("o_valid_relu", o_valid_r, {NN{1'b1}});
        chk("o_valid_none", o_valid_n, {NN{1'b1}});
        if (oq_r.size() == 0) chk("o_valid_unexpected", 1, 0);
        else begin
          chk("x_out_relu", x_out_r, oq_r.pop_front());
          chk("x_out_none", x_out_n, oq_n.pop_front());
        end
        if (lat_o_pending) begin
          chk("latency_o_valid", cyc - acc_edge, 3);
          lat_o_pending = 1'b0;
        end
      end
      if (y_valid_r) begin
        chk("y_valid_none", y_valid_n, 1);
        chk("x_ready_in_shift", x_ready_r, 0);
        if (lat_y_pending) begin
          chk("latency_y_valid", cyc - acc_edge, 4);
          lat_y_pending = 1'b0;
        end
        if (yq_r.size() == 0) chk("y_valid_unexpected", 1, 0);
        else if (y_ready) begin
          chk("y_data_relu", y_data_r, yq_r.pop_front());
          chk("y_data_none", y_data_n, yq_n.pop_front());
          chk("y_last", y_last_r, ybeat == NN - 1);
          ybeat = (ybeat == NN - 1) ? 0 : ybeat + 1;
        end else begin
          chk("y_hold", y_data_r, yq_r[0]);
        end
      end
    end
  end

  task automatic cfg(input int layer, input int neuron, input bit wv, input int wval,
                     input bit bv, input int bval, input string tag);
    bit hit, ok;
    hit = (layer == 1);
    ok  = (neuron < NN);
    weightValid = wv; biasValid = bv;
    weightValue = wval; biasValue = bval;
    config_layer_num = layer; config_neuron_num = neuron;
    @(posedge clk); #1;
    weightValid = 1'b0; biasValid = 1'b0;
    if (hit && ok) begin
      if (wv) begin
        w_m[neuron][wp_m[neuron]] = wval & 32'hFFFF;
        wp_m[neuron] = (wp_m[neuron] + 1) % NW;
      end
      if (bv) b_m[neuron] = bval & 32'hFFFF;
    end
    @(negedge clk);
    chk(tag, cfg_err_r, hit && !ok);
    chk({tag, "_none"}, cfg_err_n, hit && !ok);
  endtask

  task automatic load_all(input int wval);
    for (int k = 0; k < NN; k++)
      for (int j = 0; j < NW; j++) cfg(1, k, 1'b1, wval, 1'b0, 0, "cfg_err_load");
    @(posedge clk); #1;
  endtask

  task automatic set_x(input int v);
    for (int j = 0; j < NW; j++) xs_cur[j] = v;
  endtask

  task automatic run_frame(input bit mid_cfg, input bit junk);
    int n;
    n = 0;
    while (!x_ready_r && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < NW; i++) begin
      x_valid = 1'b1;
      x_in    = 16'(xs_cur[i]);
      if (mid_cfg && i == 2) begin
        weightValid = 1'b1; biasValid = 1'b1;
        weightValue = 32'h8000; biasValue = 32'h7FFF;
        config_layer_num = 1; config_neuron_num = 0;
      end
      chk("x_ready_beat", x_ready_r, 1);
      @(posedge clk); #1;
      acc_edge = cyc;
      x_valid = 1'b0; weightValid = 1'b0; biasValid = 1'b0;
      if (mid_cfg && i == 2) begin
        @(negedge clk);
        chk("cfg_err_midframe", cfg_err_r, 1);
      end
    end
    push_expect();
    lat_o_pending = 1'b1;
    lat_y_pending = 1'b1;
    if (junk) begin
      // Samples offered outside ACCUM must be dropped.
      x_valid = 1'b1; x_in = 16'h7FFF;
      repeat (6) @(posedge clk);
      #1 x_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((yq_r.size() != 0 || oq_r.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    chk("frame_timeout", n < 300, 1);
    @(posedge clk); #1;
  endtask

  task automatic stall3();
    int n;
    n = 0;
    while (ybeat != 1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("stall_sync_timeout", n < 200, 1);
    y_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 y_ready = 1'b1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_x_ready", x_ready_r, 0);
    chk("rst_o_valid", o_valid_r, 0);
    chk("rst_x_out",   x_out_r, 0);
    chk("rst_y_valid", y_valid_r, 0);
    chk("rst_y_data",  y_data_r, 0);
    chk("rst_y_last",  y_last_r, 0);
    chk("rst_cfg_err", cfg_err_r, 0);
    chk("rst_x_out_none", x_out_n, 0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NN; k++) begin
      b_m[k]  = 0;
      wp_m[k] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    weightValid = 1'b0; biasValid = 1'b0; x_valid = 1'b0; y_ready = 1'b1;
    weightValue = '0; biasValue = '0; config_layer_num = '0; config_neuron_num = '0;
    x_in = '0;
    model_reset();
    for (int k = 0; k < NN; k++) for (int j = 0; j < NW; j++) w_m[k][j] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b1;

    // 1.0 * 0.5 summed over four inputs
    load_all(32'h1000);
    set_x(32'h0800);
    run_frame(1'b0, 1'b0);
    wait_done();

    // Other layer ignored silently, bad neuron flagged, mid-frame write dropped
    cfg(2, 0, 1'b1, 32'hF000, 1'b0, 0, "cfg_err_other_layer");
    cfg(1, 5, 1'b1, 32'hF000, 1'b1, 32'h1000, "cfg_err_bad_neuron");
    run_frame(1'b1, 1'b1);
    wait_done();

    // Negative result: relu clamps to 0, linear gives -4.0
    load_all(32'hF000);
    set_x(32'h1000);
    run_frame(1'b0, 1'b0);
    wait_done();

    // Positive saturation
    load_all(32'h7FFF);
    set_x(32'h7FFF);
    run_frame(1'b0, 1'b0);
    wait_done();

    // Negative saturation
    load_all(32'h8000);
    set_x(32'h7FFF);
    run_frame(1'b0, 1'b0);
    wait_done();

    // Distinct per-lane bias (written with the last weight) to expose ordering,
    // and a three-cycle output stall on the second beat.
    for (int k = 0; k < NN; k++)
      for (int j = 0; j < NW; j++)
        cfg(1, k, 1'b1, 32'h1000, j == NW - 1, k * 32'h100, "cfg_err_wb");
    set_x(32'h0800);
    fork
      run_frame(1'b0, 1'b0);
      stall3();
    join
    wait_done();

    // Reset after two samples: partial sum must not leak into the next frame
    for (int i = 0; i < 2; i++) begin
      x_valid = 1'b1; x_in = 16'h0800;
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b1;
    set_x(32'h0800);
    run_frame(1'b0, 1'b0);
    wait_done();
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
